// File: rtl/game_controller.sv
// Car game sequencer: debounces the buttons, turns held directions into move strobes,
// and runs the idle/play/hit/over flow with score, lives and car re-centre pulses.

module game_debounce #(
    parameter int FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn,
    output logic level
);
    logic [1:0] sync;
    logic [3:0] cnt;

    // cnt counts consecutive frame samples disagreeing with the accepted level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (frame_tick) begin
                if (sync[1] != level) begin
                    if (cnt == 4'(FRAMES - 1)) begin
                        level <= sync[1];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end
endmodule

module game_controller #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int MOVE_DIV        = 1,
    parameter int SCORE_DIV       = 30,
    parameter int LIVES_INIT      = 3,
    parameter int RECOVER_FRAMES  = 45,
    parameter int INVULN_FRAMES   = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        collision,
    output logic [1:0]  control,
    output logic        car_reset,
    output logic [1:0]  state,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        invuln,
    output logic        game_over
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_HIT = 2'b10, S_OVER = 2'b11} st_t;

    st_t        cur, nxt;
    logic [2:0] raw, deb;
    logic       start_prev, start_rise;
    logic [1:0] dir;
    logic [3:0] mv_cnt;
    logic [7:0] sc_cnt, inv_cnt, rec_cnt;
    logic       hit_now, strobe;
    logic [1:0] control_d;
    logic       car_reset_d;

    assign raw = {btn_start, btn_right, btn_left};

    for (genvar i = 0; i < 3; i++) begin : g_db
        game_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_db (
            .clk       (clk),
            .reset     (reset),
            .frame_tick(frame_tick),
            .btn       (raw[i]),
            .level     (deb[i])
        );
    end

    assign start_rise = deb[2] & ~start_prev;
    assign dir        = (deb[1] & ~deb[0]) ? 2'b10 :
                        (deb[0] & ~deb[1]) ? 2'b01 : 2'b00;
    // a collision only counts when not invulnerable
    assign hit_now    = (cur == S_PLAY) && collision && (inv_cnt == 8'd0);
    assign strobe     = (cur == S_PLAY) && (dir != 2'b00) && frame_tick &&
                        (mv_cnt == 4'(MOVE_DIV - 1));

    assign state     = cur;
    assign invuln    = (inv_cnt != 8'd0);
    assign game_over = (cur == S_OVER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE: if (start_rise) nxt = S_PLAY;
            S_PLAY: if (hit_now)    nxt = (lives == 2'd1) ? S_OVER : S_HIT;
            S_HIT:  if (frame_tick && rec_cnt <= 8'd1) nxt = S_PLAY;
            S_OVER: if (start_rise) nxt = S_IDLE;
        endcase
    end

    always_comb begin
        control_d   = (strobe && !collision) ? dir : 2'b00;
        car_reset_d = ((cur == S_IDLE) && start_rise) || (hit_now && lives != 2'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            control    <= '0;
            car_reset  <= 1'b0;
            start_prev <= 1'b0;
            mv_cnt     <= '0;
            sc_cnt     <= '0;
            score      <= '0;
            lives      <= '0;
            inv_cnt    <= '0;
            rec_cnt    <= '0;
        end else begin
            control    <= control_d;
            car_reset  <= car_reset_d;
            start_prev <= deb[2];

            if (cur != S_PLAY || dir == 2'b00) mv_cnt <= '0;
            else if (frame_tick)               mv_cnt <= strobe ? 4'd0 : mv_cnt + 4'd1;

            unique case (cur)
                S_IDLE: if (start_rise) begin
                    score   <= '0;
                    sc_cnt  <= '0;
                    lives   <= 2'(LIVES_INIT);
                    inv_cnt <= '0;
                end
                S_PLAY: begin
                    if (hit_now) begin
                        lives   <= lives - 2'd1;
                        rec_cnt <= 8'(RECOVER_FRAMES);
                    end else if (frame_tick) begin
                        if (sc_cnt == 8'(SCORE_DIV - 1)) begin
                            sc_cnt <= '0;
                            if (score != 16'hFFFF) score <= score + 16'd1;
                        end else begin
                            sc_cnt <= sc_cnt + 8'd1;
                        end
                    end
                    if (frame_tick && inv_cnt != 8'd0 && !collision) inv_cnt <= inv_cnt - 8'd1;
                end
                S_HIT: if (frame_tick) begin
                    if (rec_cnt <= 8'd1) begin
                        rec_cnt <= '0;
                        inv_cnt <= 8'(INVULN_FRAMES);
                    end else begin
                        rec_cnt <= rec_cnt - 8'd1;
                    end
                end
                S_OVER: ;
            endcase
        end
    end
endmodule
